// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge: one transfer at a time, IDLE->SETUP->ACCESS->RESP.
// Optional ACCESS-phase timeout when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
   parameter int N = 32,
   parameter int A = 10,
   parameter int B = N / 8,
   parameter int O = 1,
   parameter int T = 16
) (
   input  logic         pclk,
   input  logic         presetn,
   // Handshakes: a beat transfers on a pclk edge where valid && ready; valid holds until then.
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_write,
   input  logic [A-1:0] cmd_addr,
   input  logic [N-1:0] cmd_wdata,
   input  logic [B-1:0] cmd_strb,
   input  logic [O-1:0] cmd_sel,
   input  logic [2:0]   cmd_prot,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic [A-1:0] paddr,
   output logic [2:0]   pprot,
   output logic [O-1:0] pselx,
   output logic         penable,
   output logic         pwrite,
   output logic [N-1:0] pwdata,
   output logic [B-1:0] pstrb,
   input  logic         pready,
   input  logic [N-1:0] prdata,
   input  logic         pslverr,
   output logic [1:0]   fsm_state
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   sel_ok;
   logic   timed_out;

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign fsm_state = state;
   assign accept    = cmd_valid && cmd_ready;
   // Exactly one select bit set; anything else is rejected without touching the bus.
   assign sel_ok    = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - O'(1))) == '0);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(T + 1);
   logic [CW-1:0] tcnt;

   // Fires on the edge that closes the T-th ACCESS cycle; a simultaneous pready takes priority.
   assign timed_out = !pready && (tcnt == CW'(T - 1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)              tcnt <= '0;
      else if (state != ACCESS)  tcnt <= '0;
      else                       tcnt <= tcnt + CW'(1);
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = sel_ok ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready || timed_out) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pselx     <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         pprot     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  paddr     <= cmd_addr;
                  pwrite    <= cmd_write;
                  pwdata    <= cmd_wdata;
                  pstrb     <= cmd_write ? cmd_strb : '0;
                  pprot     <= cmd_prot;
                  penable   <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= !sel_ok;
                  pselx     <= sel_ok ? cmd_sel : '0;
               end
            end
            SETUP: penable <= 1'b1;
            ACCESS: begin
               if (pready) begin
                  pselx     <= '0;
                  penable   <= 1'b0;
                  rsp_err   <= pslverr;
                  rsp_rdata <= pwrite ? '0 : prdata;
               end else if (timed_out) begin
                  pselx     <= '0;
                  penable   <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a behavioural APB memory slave and a response scoreboard.
module tb_apb_master_bridge;
   localparam int N = 32;
   localparam int A = 10;
   localparam int B = N / 8;
   localparam int O = 2;
   localparam int T = 16;

   logic         pclk, presetn;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [A-1:0] cmd_addr;
   logic [N-1:0] cmd_wdata;
   logic [B-1:0] cmd_strb;
   logic [O-1:0] cmd_sel;
   logic [2:0]   cmd_prot;
   logic         rsp_valid, rsp_ready, rsp_err;
   logic [N-1:0] rsp_rdata;
   logic [A-1:0] paddr;
   logic [2:0]   pprot;
   logic [O-1:0] pselx;
   logic         penable, pwrite;
   logic [N-1:0] pwdata;
   logic [B-1:0] pstrb;
   logic         pready, pslverr;
   logic [N-1:0] prdata;
   logic [1:0]   fsm_state;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];
   logic         exp_err_q[$];

   // Slave model controls
   int          wait_cycles = 0;
   logic        stall_all = 1'b0;
   logic        err_flag = 1'b0;
   int          wcnt;
   logic [N-1:0] mem [0:63];
   int          acc_total = 0;
   logic [O-1:0] prev_psel = '0;

   apb_master_bridge #(.N(N), .A(A), .B(B), .O(O), .T(T)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .cmd_sel(cmd_sel), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pprot(pprot), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .fsm_state(fsm_state)
   );

   // Clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // APB memory slave: word addressed, wait states counted from the first ACCESS cycle
   initial for (int i = 0; i < 64; i++) mem[i] = '0;
   assign pready  = !stall_all && (wcnt >= wait_cycles);
   assign prdata  = mem[paddr[7:2]];
   assign pslverr = err_flag;

   always @(posedge pclk or negedge presetn) begin
      if (!presetn) wcnt <= 0;
      else if (pselx != '0 && penable) begin
         if (pready) begin
            wcnt <= 0;
            if (pwrite)
               for (int b = 0; b < B; b++)
                  if (pstrb[b]) mem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
         end else wcnt <= wcnt + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: scoreboard pop on response handshake, plus APB phase ordering
   always @(negedge pclk) begin
      if (presetn && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
         else begin
            check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            check("rsp_err", rsp_err, exp_err_q.pop_front());
         end
      end
      if (pselx != '0 && penable) begin
         acc_total++;
         check("access_after_setup", prev_psel, pselx);
      end
      if (pselx != '0 && !penable) check("idle_before_setup", prev_psel, 0);
      prev_psel = pselx;
   end

   // Driver tasks: called at posedge+#1, return at posedge+#1 of the accept edge
   task automatic issue(input logic w, input logic [A-1:0] a, input logic [N-1:0] d,
                        input logic [B-1:0] s, input logic [O-1:0] sel, input logic [2:0] prot,
                        input logic push, input logic [N-1:0] er, input logic ee);
      logic accepted = 1'b0;
      if (push) begin
         exp_q.push_back(er);
         exp_err_q.push_back(ee);
      end
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      cmd_strb = s; cmd_sel = sel; cmd_prot = prot;
      for (int k = 0; k < 300 && !accepted; k++) begin
         @(negedge pclk);
         if (cmd_ready) accepted = 1'b1;
         @(posedge pclk); #1;
      end
      cmd_valid = 1'b0;
      if (!accepted) check("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge pclk);
         if (exp_q.size() == 0) break;
      end
      if (k == 300) check("rsp_wait_timeout", exp_q.size(), 0);
      @(posedge pclk); #1;
   endtask

   task automatic pulse_reset();
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
   endtask

   initial begin
      int bad, a0, n;
      logic [N-1:0] snap_d, snap_r;
      logic [A-1:0] snap_a;

      presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; cmd_sel = '0; cmd_prot = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge pclk);
      #1 presetn = 1'b1;

      // Reset state
      @(negedge pclk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      check("rst_apb_ctl", {pselx, penable, pwrite, pprot, pstrb}, 0);
      check("rst_apb_data", {paddr, pwdata}, 0);
      @(posedge pclk); #1;

      // Minimum-latency write
      issue(1, 10'h004, 32'hDEADBEEF, 4'hF, 2'b01, 3'b000, 1, 32'h0, 0);
      @(negedge pclk);
      check("wr_setup_sel", {pselx, penable}, {2'b01, 1'b0});
      check("wr_setup_bus", {pwrite, paddr, pwdata, pstrb}, {1'b1, 10'h004, 32'hDEADBEEF, 4'hF});
      @(negedge pclk);
      check("wr_access", {pselx, penable, rsp_valid}, {2'b01, 1'b1, 1'b0});
      @(negedge pclk);
      check("wr_rsp_cycle3", {rsp_valid, pselx, penable}, {1'b1, 2'b00, 1'b0});
      wait_done();

      // Read back; strobes must be zero on reads
      issue(0, 10'h004, 32'h12345678, 4'hF, 2'b01, 3'b000, 1, 32'hDEADBEEF, 0);
      @(negedge pclk);
      check("rd_pstrb_zero", {pwrite, pstrb}, 0);
      wait_done();

      // Partial-strobe write to second slave with protection bits, then read back
      issue(1, 10'h004, 32'h11223344, 4'h5, 2'b10, 3'b101, 1, 32'h0, 0);
      @(negedge pclk);
      check("pw_setup", {pselx, pprot, pstrb}, {2'b10, 3'b101, 4'h5});
      wait_done();
      issue(0, 10'h004, 32'h0, 4'h0, 2'b10, 3'b000, 1, 32'hDE22BE44, 0);
      wait_done();

      // Three wait states with slave error: outputs stable for four ACCESS cycles
      wait_cycles = 3; err_flag = 1'b1;
      a0 = acc_total;
      issue(1, 10'h008, 32'hA5A5_0F0F, 4'hF, 2'b01, 3'b010, 1, 32'h0, 1);
      @(negedge pclk);
      snap_a = paddr; snap_d = pwdata; bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         if (paddr !== snap_a || pwdata !== snap_d || pselx !== 2'b01 || !penable ||
             !pwrite || pstrb !== 4'hF || pprot !== 3'b010) bad++;
      end
      check("wait_stable", bad, 0);
      wait_done();
      check("wait_access_cycles", acc_total - a0, 4);
      wait_cycles = 0; err_flag = 1'b0;

      // Response back-pressure
      rsp_ready = 1'b0;
      issue(0, 10'h008, 32'h0, 4'h0, 2'b01, 3'b000, 1, 32'hA5A50F0F, 0);
      for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge pclk);
      snap_r = rsp_rdata; bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         if (!rsp_valid || rsp_rdata !== snap_r || cmd_ready || pselx !== '0) bad++;
      end
      check("bp_hold", bad, 0);
      @(posedge pclk); #1 rsp_ready = 1'b1;
      wait_done();

      // Bad selects: no bus activity, error response one cycle after accept
      a0 = acc_total;
      issue(0, 10'h004, 32'h0, 4'h0, 2'b11, 3'b000, 1, 32'h0, 1);
      @(negedge pclk);
      check("badsel_multi", {rsp_valid, pselx}, {1'b1, 2'b00});
      wait_done();
      issue(1, 10'h00C, 32'hFFFF_FFFF, 4'hF, 2'b00, 3'b000, 1, 32'h0, 1);
      @(negedge pclk);
      check("badsel_zero", {rsp_valid, pselx}, {1'b1, 2'b00});
      wait_done();
      check("badsel_no_access", acc_total - a0, 0);

      // Back-to-back commands
      issue(1, 10'h020, 32'h0BADCAFE, 4'hF, 2'b10, 3'b000, 1, 32'h0, 0);
      issue(0, 10'h020, 32'h0, 4'h0, 2'b10, 3'b000, 1, 32'h0BADCAFE, 0);
      wait_done();

      // pready arriving on the 16th ACCESS cycle completes normally
      wait_cycles = 15;
      issue(0, 10'h020, 32'h0, 4'h0, 2'b01, 3'b000, 1, 32'h0BADCAFE, 0);
      wait_done();
      wait_cycles = 0;

      // Reset during ACCESS aborts the transfer
      wait_cycles = 5;
      issue(1, 10'h010, 32'hCAFEF00D, 4'hF, 2'b01, 3'b000, 0, 32'h0, 0);
      @(negedge pclk); @(negedge pclk);
      #2 presetn = 1'b0;
      #1 check("rst_mid_abort", {pselx, penable, fsm_state}, 0);
      @(posedge pclk); #1 presetn = 1'b1;
      @(negedge pclk);
      check("rst_mid_ready", cmd_ready, 1);
      n = 0;
      repeat (10) begin @(negedge pclk); if (rsp_valid) n++; end
      check("rst_mid_no_rsp", n, 0);
      @(posedge pclk); #1;
      wait_cycles = 0;

      // Slave never ready
      stall_all = 1'b1;
      a0 = acc_total;
`ifdef APB_MASTER_TIMEOUT_EN
      issue(1, 10'h030, 32'h1, 4'hF, 2'b01, 3'b000, 1, 32'h0, 1);
      wait_done();
      check("timeout_access_cycles", acc_total - a0, T);
`else
      issue(1, 10'h030, 32'h1, 4'hF, 2'b01, 3'b000, 0, 32'h0, 0);
      n = 0;
      repeat (100) begin @(negedge pclk); if (rsp_valid) n++; end
      check("stall_no_rsp", n, 0);
      check("stall_still_access", {pselx, penable}, {2'b01, 1'b1});
      @(posedge pclk); #1;
      pulse_reset();
`endif
      stall_all = 1'b0;

      // Bridge still functional afterwards
      issue(0, 10'h004, 32'h0, 4'h0, 2'b01, 3'b000, 1, 32'hDE22BE44, 0);
      wait_done();
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter N, default 32, data bus width in bits.
REQ-002 SHALL have parameter A, default 10, address width in bits.
REQ-003 SHALL have parameter B, default N/8, number of byte lanes.
REQ-004 SHALL have parameter O, default 1, slave-select width (one-hot).
REQ-005 SHALL have parameter T, default 16, ACCESS-phase timeout in cycles; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-006 SHALL have one clock and an asynchronous active-low reset: pclk  in  1  clock; presetn  in  1  asynchronous reset, active low.
REQ-007 cmd_valid  in  1  command present; cmd_ready  out  1  command accepted.
REQ-008 cmd_write  in  1  1=write; cmd_addr  in  A  address; cmd_wdata  in  N  write data; cmd_strb  in  B  byte strobes; cmd_sel  in  O  one-hot target; cmd_prot  in  3  protection.
REQ-009 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed; rsp_rdata  out  N  read data; rsp_err  out  1  transfer failed.
REQ-010 paddr  out  A; pprot  out  3; pselx  out  O; penable  out  1; pwrite  out  1; pwdata  out  N; pstrb  out  B.
REQ-011 pready  in  1; prdata  in  N; pslverr  in  1.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all APB outputs driven from registers.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a pclk edge with cmd_valid && cmd_ready.
REQ-014 On acceptance, all cmd_* fields SHALL be captured; next state SETUP.
REQ-015 SETUP: pselx=captured cmd_sel, penable=0, paddr/pwrite/pprot/pwdata/pstrb valid; lasts exactly one cycle, then ACCESS.
REQ-016 ACCESS: pselx held, penable=1; all APB address/control/data outputs stable until pready=1 is sampled.
REQ-017 On a pclk edge in ACCESS with pready=1: capture rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; pselx=0, penable=0; next state RESP.
REQ-018 RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready, then IDLE.
REQ-019 Minimum latency: accept at edge 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid=1 at cycle 3 when pready is already 1.
REQ-020 pstrb SHALL be driven 0 for reads regardless of cmd_strb.
REQ-021 Back-to-back: next command accepted no earlier than the cycle after the response handshake; pselx SHALL be 0 for at least one cycle between transfers.
REQ-022 cmd_sel with zero or multiple bits set SHALL complete without APB activity (pselx stays 0): rsp_err=1, rsp_rdata=0, direct IDLE->RESP after one cycle.
REQ-023 pready and prdata SHALL be ignored outside ACCESS.

Reset
REQ-024 presetn=0 SHALL immediately force state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, timeout counter=0.
REQ-025 Reset asserted mid-transfer SHALL abort it with no response issued; the command is lost.

Configuration
REQ-026 Macro APB_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles; if T cycles elapse with pready=0, SHALL drop pselx/penable, set rsp_err=1, rsp_rdata=0, enter RESP.
REQ-027 pready=1 on the same edge the counter reaches T SHALL be treated as normal completion (pready wins).
REQ-028 Macro undefined: no counter logic; ACCESS waits indefinitely for pready.

Verification
REQ-029 Write addr=0x004, data=0xDEADBEEF, strb=0xF, sel=1, pready=1 -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
REQ-030 Read addr=0x004 after REQ-029 against APBSlaveMemory -> rsp_rdata=0xDEADBEEF, pstrb=0 during transfer.
REQ-031 pready held 0 for 3 ACCESS cycles, pslverr=1 on completion -> APB outputs stable for 4 ACCESS cycles, rsp_err=1.
REQ-032 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no pselx activity.
REQ-033 presetn pulsed low during ACCESS -> pselx=0, penable=0 immediately, rsp_valid never asserted, cmd_ready=1 after release.
REQ-034 APB_MASTER_TIMEOUT_EN, T=16, pready tied 0 -> rsp_err=1 after 16 ACCESS cycles; without macro, rsp_valid stays 0 for 100 cycles.
